sifh_acq_scheduler: RTL
=======================

// Module: sifh_acq_scheduler
// PURPOSE
// Acquisition scheduler in front of the SiFH histogram FSM. Several pixel TDC streams share one histogram RAM.
// Per frame the block runs four phases in order: zero the RAM, arbitrate pixel timestamps round-robin into the
// single FSM data port for ACQ_NUM laser cycles, drain the FSM pipeline, then hand off to peak readout.
// PARAMETERS
// N_REQ      4    pixel requesters per RAM (= PIXEL_NUM_PER_RAM); N_REQ >= 2
// NP         10   timestamp width (= Np)
// RAM_ADDR   12   histogram RAM address width; clear sweeps 2**RAM_ADDR words
// ACQ_NUM    16   laser cycles per frame
// DRAIN_CYC  3    idle cycles after the last accepted event (FSM read-modify-write latency)
// PORTS
// clk        in   1            system clock, rising edge
// res        in   1            asynchronous reset, active low
// start      in   1            one-cycle frame start pulse; ignored unless state is IDLE
// abort      in   1            synchronous abort; any state -> IDLE on the next edge
// cycStart   in   1            laser-cycle strobe, one cycle wide
// reqValid   in   N_REQ        per-pixel timestamp valid
// reqData    in   N_REQ*NP     packed timestamps; pixel i occupies bits [i*NP +: NP]
// reqReady   out  N_REQ        one-hot grant; combinational from the arbiter and the current state
// wrEn       out  1            registered event strobe to the SiFH FSM
// data       out  NP           registered timestamp to the SiFH FSM
// pixSel     out  clog2(N_REQ) registered source pixel of data
// clrEn      out  1            RAM clear write enable
// clrAddr    out  RAM_ADDR     RAM clear address
// rdStart    out  1            one-cycle pulse that starts peak readout
// rdDone     in   1            readout complete, one-cycle pulse
// busy       out  1            high in every state except IDLE
// done       out  1            one-cycle pulse at frame end
// acqCnt     out  clog2(ACQ_NUM+1)  laser cycles completed in the current frame
// BEHAVIOUR
// - Reset values: state IDLE; every output 0; round-robin pointer 0; acqCnt 0.
// - States: IDLE -> CLEAR -> ACQ -> DRAIN -> READ -> FIN -> IDLE.
// - IDLE: a start pulse moves to CLEAR. In every other state start is ignored, with no error flag.
// - CLEAR: clrEn=1 and clrAddr counts 0..2**RAM_ADDR-1, one word per cycle.
//   - On the last address the next state is ACQ; clrAddr returns to 0 and acqCnt clears to 0.
//   - reqReady stays 0 for the whole of CLEAR.
// - ACQ arbitration:
//   - Grant goes to the first valid index searching upward from (last granted + 1) mod N_REQ.
//   - At most one grant per cycle. An accept is reqValid[i] & reqReady[i].
//   - Each accept gives, on the next edge: wrEn=1, data=reqData[i], pixSel=i. Latency is 1 cycle.
//   - In a cycle with no accept, wrEn=0 and data/pixSel hold their last value.
// - ACQ cycle counting:
//   - cycStart increments acqCnt.
//   - The terminating strobe is the one seen while acqCnt==ACQ_NUM-1.
//     - In that cycle reqReady is forced to 0, so an event coinciding with the strobe is not accepted.
//     - acqCnt becomes ACQ_NUM and the next state is DRAIN.
//   - Events that arrive before the first cycStart of the frame are accepted.
// - DRAIN: no grants; wrEn=0. After exactly DRAIN_CYC cycles the next state is READ.
// - READ: rdStart=1 for the first cycle only, then wait for rdDone.
//   - rdDone that arrives while not in READ is ignored.
//   - rdDone in the same cycle as rdStart is accepted.
// - FIN: done=1 for 1 cycle, then IDLE. acqCnt holds ACQ_NUM until the next frame's CLEAR completes.
// - abort: on the next edge state=IDLE and all strobes=0 (wrEn, clrEn, rdStart, done).
//   - The RR pointer and acqCnt are retained.
//   - abort has priority over start, cycStart and rdDone in the same cycle.
// - Reset asserted mid-frame forces all reset values immediately; no partial clear resumes after reset.
// STRUCTURE
// - NP, RAM_ADDR, ACQ_NUM and PIXEL_NUM_PER_RAM come from the shared parametersSiFH.vh.
// - State encodings are added to parametersSiFH.vh as `define constants.
// - Sub-module sifh_rr_arb(N_REQ):
//   - inputs: reqValid, enable; output: one-hot grant.
//   - It keeps the pointer register and updates it on an accept.
// - sifh_acq_scheduler holds the FSM, the clear counter, the cycle counter, the drain counter and the output registers.
// TESTING
// 1. Reset then start, RAM_ADDR=4 -> clrEn high 16 cycles, clrAddr 0..15, then busy=1 in ACQ, acqCnt=0.
// 2. All 4 reqValid held high -> grants 0,1,2,3,0 on consecutive cycles;
//    wrEn/data/pixSel follow 1 cycle later, with data matching the packed lane.
// 3. reqValid=4'b1010, last grant=3 -> grant 1 then 3 then 1; lanes 0 and 2 are never granted.
// 4. ACQ_NUM=2: the second cycStart coincides with reqValid=1 -> reqReady=0 that cycle;
//    exactly 3 idle cycles follow, then rdStart pulse, then rdDone -> done pulse and IDLE.
// 5. start pulsed during ACQ -> ignored, frame unaffected; abort during CLEAR at clrAddr=7 -> IDLE next edge, clrEn=0.
// 6. res low during READ -> all outputs 0 immediately; a fresh start restarts from clrAddr=0.

Source files
------------

// File: rtl/sifh_acq_scheduler_pkg.sv
// Shared types and default geometry for the SiFH acquisition scheduler.
// The frame walks IDLE -> CLEAR -> ACQ -> DRAIN -> READ -> FIN -> IDLE.
package sifh_acq_scheduler_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_NP        = 10;
    localparam int DEF_RAM_ADDR  = 12;
    localparam int DEF_ACQ_NUM   = 16;
    localparam int DEF_DRAIN_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_READ  = 3'd4,
        ST_FIN   = 3'd5
    } acqState_t;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic int ohToIdx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sifh_acq_scheduler_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer,
// then moves the pointer to the slot just past the winner.
module sifh_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic [N_REQ-1:0] reqValid,
    input  logic             enable,
    output logic [N_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptrReg;
    logic [PTR_W-1:0] ptrNext;

    always_comb begin
        int  idx;
        logic found;
        grant   = '0;
        ptrNext = ptrReg;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptrReg) + k) % N_REQ;
            if (enable && !found && reqValid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptrNext    = PTR_W'((idx + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ptrReg <= '0;
        end else begin
            ptrReg <= ptrNext;
        end
    end

endmodule

// File: rtl/sifh_acq_scheduler.sv
// Frame scheduler for one SiFH histogram RAM: clears the RAM, funnels pixel
// timestamps into the single FSM port for ACQ_NUM laser cycles, drains, then reads out.
module sifh_acq_scheduler
    import sifh_acq_scheduler_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int NP        = DEF_NP,
    parameter int RAM_ADDR  = DEF_RAM_ADDR,
    parameter int ACQ_NUM   = DEF_ACQ_NUM,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           cycStart,
    input  logic [N_REQ-1:0]               reqValid,
    input  logic [N_REQ*NP-1:0]            reqData,
    output logic [N_REQ-1:0]               reqReady,
    output logic                           wrEn,
    output logic [NP-1:0]                  data,
    output logic [$clog2(N_REQ)-1:0]       pixSel,
    output logic                           clrEn,
    output logic [RAM_ADDR-1:0]            clrAddr,
    output logic                           rdStart,
    input  logic                           rdDone,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(ACQ_NUM+1)-1:0]   acqCnt
);

    localparam int PIX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ACQ_NUM + 1);
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    acqState_t           stateReg, stateNext;
    logic [RAM_ADDR-1:0] clrAddrReg;
    logic [CNT_W-1:0]    acqCntReg;
    logic [DRN_W-1:0]    drainCntReg;
    logic                rdIssuedReg;
    logic                wrEnReg;
    logic [NP-1:0]       dataReg;
    logic [PIX_W-1:0]    pixSelReg;

    logic [N_REQ-1:0]    grant;
    logic                lastCycle;
    logic                arbEnable;
    logic                accept;
    logic [NP-1:0]       selData;
    logic [NP-1:0]       laneMasked [N_REQ];

    // The terminating strobe closes the window, so an event on that same cycle is refused.
    assign lastCycle = cycStart && (acqCntReg == CNT_W'(ACQ_NUM - 1));
    assign arbEnable = (stateReg == ST_ACQ) && !abort && !lastCycle;
    assign accept    = |grant;
    assign reqReady  = grant;

    sifh_rr_arb #(.N_REQ(N_REQ)) uArb (
        .clk      (clk),
        .res      (res),
        .reqValid (reqValid),
        .enable   (arbEnable),
        .grant    (grant)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gLane
        assign laneMasked[gi] = grant[gi] ? reqData[gi*NP +: NP] : '0;
    end

    always_comb begin
        selData = '0;
        for (int i = 0; i < N_REQ; i++) selData |= laneMasked[i];
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) stateReg <= ST_IDLE;
        else      stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        if (abort) begin
            stateNext = ST_IDLE;
        end else begin
            case (stateReg)
                ST_IDLE:  if (start) stateNext = ST_CLEAR;
                ST_CLEAR: if (clrAddrReg == '1) stateNext = ST_ACQ;
                ST_ACQ:   if (lastCycle) stateNext = ST_DRAIN;
                ST_DRAIN: if (drainCntReg == DRN_W'(DRAIN_CYC - 1)) stateNext = ST_READ;
                ST_READ:  if (rdDone) stateNext = ST_FIN;
                ST_FIN:   stateNext = ST_IDLE;
                default:  stateNext = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (stateReg != ST_IDLE);
        clrEn   = (stateReg == ST_CLEAR);
        rdStart = (stateReg == ST_READ) && !rdIssuedReg;
        done    = (stateReg == ST_FIN);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            clrAddrReg  <= '0;
            acqCntReg   <= '0;
            drainCntReg <= '0;
            rdIssuedReg <= 1'b0;
            wrEnReg     <= 1'b0;
            dataReg     <= '0;
            pixSelReg   <= '0;
        end else begin
            clrAddrReg  <= (stateReg == ST_CLEAR && stateNext == ST_CLEAR) ? clrAddrReg + 1'b1 : '0;
            drainCntReg <= (stateReg == ST_DRAIN && stateNext == ST_DRAIN) ? drainCntReg + 1'b1 : '0;
            rdIssuedReg <= (stateReg == ST_READ) && (stateNext == ST_READ);
            if (stateReg == ST_CLEAR && stateNext == ST_ACQ) begin
                acqCntReg <= '0;
            end else if (stateReg == ST_ACQ && cycStart && !abort) begin
                acqCntReg <= acqCntReg + 1'b1;
            end
            wrEnReg <= accept;
            if (accept) begin
                dataReg   <= selData;
                pixSelReg <= PIX_W'(ohToIdx(32'(grant)));
            end
        end
    end

    assign clrAddr = clrAddrReg;
    assign acqCnt  = acqCntReg;
    assign wrEn    = wrEnReg;
    assign data    = dataReg;
    assign pixSel  = pixSelReg;

endmodule
